// File: rtl/de_pipeline.sv
// Enabled shift pipeline of DEPTH stages, each carrying WIDTH data bits plus a valid bit.
// Tracks the number of valid tokens in flight incrementally; flush and reset clear everything.
module de_pipeline #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         E,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             D,
  input  logic                         D_valid,
  output logic [WIDTH-1:0]             Q,
  output logic                         Q_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CntW = $clog2(DEPTH+1);
  localparam logic [CntW-1:0] CntOne = CntW'(1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [CntW-1:0]  count_q;
  logic [CntW-1:0]  count_d;
  logic             tok_in;
  logic             tok_out;

  // D_valid is only looked at when E=1, so an X there cannot leak into state while holding.
  always_comb begin
    tok_in  = 1'b0;
    tok_out = valid_q[DEPTH-1];
    if (E) begin
      tok_in = D_valid;
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_d[i]  = '0;
        valid_d[i] = 1'b0;
      end
    end else if (E) begin
      data_d[0]  = D;
      valid_d[0] = D_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i]  = data_q[i-1];
        valid_d[i] = valid_q[i-1];
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (E) begin
      if (tok_in && !tok_out) begin
        count_d = count_q + CntOne;
      end else if (!tok_in && tok_out) begin
        count_d = count_q - CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign Q       = data_q[DEPTH-1];
  assign Q_valid = valid_q[DEPTH-1];
  assign count   = count_q;

endmodule
